// File: rtl/hdl_lib_pkg.sv
// Shared helpers for small boundary blocks: constant-width math and common limits.
package hdl_lib_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A counter that only ever holds 0 still needs one bit to exist.
    function automatic int cnt_width(input int cycles);
        return (clog2(cycles) < 1) ? 1 : clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_filter_bank_if.sv
// Async-level inputs and filtered level/edge outputs of sync_filter_bank.
interface sync_filter_bank_if #(
    parameter int CHANNELS = 8
);
    logic [CHANNELS-1:0] async_in;
    logic                filter_en;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic                any_change;

    modport master (
        output async_in, filter_en,
        input  level_out, rise_pulse, fall_pulse, any_change
    );

    modport slave (
        input  async_in, filter_en,
        output level_out, rise_pulse, fall_pulse, any_change
    );
endinterface

// File: rtl/sync_filter_channel.sv
// One channel: synchroniser chain, glitch-filter counter, filtered level and edge pulses.
module sync_filter_channel
    import hdl_lib_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter bit RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic filter_en,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_d
);

    localparam int             CW      = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CYCLES - 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("sync_filter_channel: SYNC_STAGES must be at least 2");
    end

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Bypass accepts on the first differing synced cycle; the counter stays at 0.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (!filter_en || cnt_q == CNT_MAX) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rise_d   = level_d & ~level_q;
        fall_d   = ~level_d & level_q;
        change_d = rise_d | fall_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent async-level synchronisers with glitch filters and edge pulses.
module sync_filter_bank
    import hdl_lib_pkg::*;
#(
    parameter int                  CHANNELS      = 8,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    sync_filter_bank_if.slave bus
);

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] change_d;
    logic                any_change_q, any_change_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sync_filter_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_VALUE  (RESET_VALUE[g])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .async_in  (bus.async_in[g]),
            .filter_en (bus.filter_en),
            .level_out (level[g]),
            .rise_pulse(rise[g]),
            .fall_pulse(fall[g]),
            .change_d  (change_d[g])
        );
    end

    // Reduced from the channels' next-state so it lines up with the pulse registers.
    always_comb begin
        any_change_d = |change_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign bus.level_out  = level;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;
    assign bus.any_change = any_change_q;

endmodule
